// File: rtl/key_pkg.sv
// Shared constants and per-channel state encoding for the multi-key debouncer.
package key_pkg;

  localparam int unsigned KEY_CNT_MAX       = 20'hF_FFFF;
  localparam int unsigned KEY_HOLD_CYCLES   = 24'd5_000_000;
  localparam int unsigned KEY_REPEAT_CYCLES = 24'd1_000_000;

  typedef enum logic [1:0] {
    KEY_RELEASED = 2'd0,
    KEY_PRESSED  = 2'd1,
    KEY_HELD     = 2'd2
  } key_state_e;

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key: 2-FF synchroniser, mismatch counter, RELEASED/PRESSED/HELD
// state machine and hold/auto-repeat timers.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX       = KEY_CNT_MAX,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned HOLD_CYCLES   = KEY_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = KEY_REPEAT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic key_in,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold,
  output logic o_repeat
);

  localparam int   CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic REL_LVL = (ACTIVE_LOW != 0);
  localparam logic HOLD_EN = (HOLD_CYCLES != 0);
  localparam logic REP_EN  = (HOLD_CYCLES != 0) && (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [23:0]      HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0]      REP_LAST  = 24'(REPEAT_CYCLES - 1);

  logic             sync_p0, sync_p1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [23:0]      hold_cnt, hold_nxt;
  logic [23:0]      rep_cnt, rep_nxt;
  key_state_e       state, state_nxt;
  logic             pressed_s, accept;
  logic             press_nxt, release_nxt, repeat_nxt;

  // Stage p0/p1: metastability guard on the raw pin
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_p0   <= REL_LVL;
      sync_p1   <= REL_LVL;
      cnt       <= '0;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      state     <= KEY_RELEASED;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_repeat  <= 1'b0;
    end else begin
      sync_p0   <= key_in;
      sync_p1   <= sync_p0;
      cnt       <= cnt_nxt;
      hold_cnt  <= hold_nxt;
      rep_cnt   <= rep_nxt;
      state     <= state_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
      o_repeat  <= repeat_nxt;
    end
  end

  assign o_level   = (state != KEY_RELEASED);
  assign o_hold    = (state == KEY_HELD);
  assign pressed_s = sync_p1 ^ REL_LVL;

  always_comb begin
    cnt_nxt     = cnt;
    hold_nxt    = hold_cnt;
    rep_nxt     = rep_cnt;
    state_nxt   = state;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    repeat_nxt  = 1'b0;
    accept      = 1'b0;

    // Any cycle of agreement throws away the mismatch run
    if (pressed_s == o_level) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      accept  = 1'b1;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end

    case (state)
      KEY_RELEASED: begin
        hold_nxt = '0;
        rep_nxt  = '0;
        if (accept) begin
          state_nxt = KEY_PRESSED;
          press_nxt = 1'b1;
        end
      end
      KEY_PRESSED: begin
        if (accept) begin
          state_nxt   = KEY_RELEASED;
          release_nxt = 1'b1;
          hold_nxt    = '0;
          rep_nxt     = '0;
        end else if (HOLD_EN) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt  = KEY_HELD;
            repeat_nxt = 1'b1;
            rep_nxt    = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
      end
      KEY_HELD: begin
        // Release wins over a repeat that would land on the same edge
        if (accept) begin
          state_nxt   = KEY_RELEASED;
          release_nxt = 1'b1;
          hold_nxt    = '0;
          rep_nxt     = '0;
        end else if (REP_EN) begin
          if (rep_cnt == REP_LAST) begin
            repeat_nxt = 1'b1;
            rep_nxt    = '0;
          end else begin
            rep_nxt = rep_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = KEY_RELEASED;
        hold_nxt  = '0;
        rep_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_debounce_multi.sv
// N independent key debouncers with press/release strobes and hold/auto-repeat.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned CNT_MAX       = KEY_CNT_MAX,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned HOLD_CYCLES   = KEY_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = KEY_REPEAT_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_hold,
  output logic [N_KEYS-1:0] o_repeat
);

  for (genvar i = 0; i < N_KEYS; i++) begin : gen_chan
    key_debounce_chan #(
      .CNT_MAX       (CNT_MAX),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .key_in    (key_in[i]),
      .o_level   (o_level[i]),
      .o_press   (o_press[i]),
      .o_release (o_release[i]),
      .o_hold    (o_hold[i]),
      .o_repeat  (o_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: a behavioural model predicts every
// output each cycle, plus directed latency checks for the key scenarios.
module tb_key_debounce_multi;

  localparam int NK  = 4;
  localparam int CNT = 8;
  localparam int HLD = 32;
  localparam int REP = 10;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] o_level, o_press, o_release, o_hold, o_repeat;

  key_debounce_multi #(
    .N_KEYS        (NK),
    .CNT_MAX       (CNT),
    .ACTIVE_LOW    (1),
    .HOLD_CYCLES   (HLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .key_in    (key_in),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_hold    (o_hold),
    .o_repeat  (o_repeat)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] hold;
    logic [NK-1:0] rep;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
  endtask

  // Behavioural model state, indexed by channel
  bit m_s0[NK], m_s1[NK], m_lvl[NK], m_hold[NK];
  int m_run[NK], m_age[NK], m_hage[NK];

  task automatic model_step(input logic [NK-1:0] key, input logic rst_n, output exp_t e);
    e = '0;
    for (int i = 0; i < NK; i++) begin
      if (!rst_n) begin
        m_s0[i] = 1'b1; m_s1[i] = 1'b1; m_lvl[i] = 1'b0; m_hold[i] = 1'b0;
        m_run[i] = 0; m_age[i] = 0; m_hage[i] = 0;
      end else begin
        bit s, was, acc;
        s   = ~m_s1[i];
        was = m_lvl[i];
        acc = 1'b0;
        m_s1[i] = m_s0[i];
        m_s0[i] = key[i];
        if (s != was) begin
          m_run[i]++;
          if (m_run[i] == CNT) begin
            acc = 1'b1; m_run[i] = 0; m_lvl[i] = s;
          end
        end else begin
          m_run[i] = 0;
        end
        if (acc && s)  e.press[i] = 1'b1;
        if (acc && !s) begin
          e.rel[i] = 1'b1; m_hold[i] = 1'b0; m_age[i] = 0; m_hage[i] = 0;
        end else if (was) begin
          if (m_hold[i]) begin
            m_hage[i]++;
            if (m_hage[i] % REP == 0) e.rep[i] = 1'b1;
          end else begin
            m_age[i]++;
            if (m_age[i] == HLD) begin
              m_hold[i] = 1'b1; e.rep[i] = 1'b1; m_hage[i] = 0;
            end
          end
        end
      end
      e.level[i] = m_lvl[i];
      e.hold[i]  = m_hold[i];
    end
  endtask

  // One clock edge: predict, clock, then compare away from the edge
  task automatic step();
    exp_t e;
    model_step(key_in, i_rst_n, e);
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    check("level",   32'(o_level),   32'(e.level));
    check("press",   32'(o_press),   32'(e.press));
    check("release", 32'(o_release), 32'(e.rel));
    check("hold",    32'(o_hold),    32'(e.hold));
    check("repeat",  32'(o_repeat),  32'(e.rep));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int  n;
  bit  seen;

  initial begin
    // Reset and idle with all keys released
    i_rst_n = 1'b0; key_in = '1;
    run(3);
    i_rst_n = 1'b1;
    run(50);
    // Long reset with key 0 low: nothing may escape
    i_rst_n = 1'b0; key_in[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if ({o_level, o_press, o_release, o_hold, o_repeat} != '0) seen = 1'b1;
    end
    check("rst_quiet", 32'(seen), 32'd0);
    key_in = '1;
    run(3);
    i_rst_n = 1'b1;
    run(10);

    // Key 0 press latency: strobe on edge CNT+2
    key_in[0] = 1'b0;
    n = 0;
    do begin step(); n++; end while (!o_press[0] && n < 40);
    check("press0_lat", 32'(n), 32'(CNT + 2));
    check("press0_lvl", 32'(o_level), 32'b0001);
    run(5);

    // Key 1 glitches shorter than CNT never register
    seen = 1'b0;
    for (int g = 0; g < 5; g++) begin
      key_in[1] = 1'b0;
      for (int k = 0; k < 7; k++) begin step(); if (o_level[1] | o_press[1] | o_release[1]) seen = 1'b1; end
      key_in[1] = 1'b1;
      step(); if (o_level[1] | o_press[1] | o_release[1]) seen = 1'b1;
    end
    check("glitch_quiet", 32'(seen), 32'd0);
    key_in[1] = 1'b0;
    run(20);
    check("glitch_final_lvl", 32'(o_level[1]), 32'd1);
    key_in[1] = 1'b1;
    run(15);

    // Key 2 hold entry and auto-repeat spacing
    key_in[2] = 1'b0;
    n = 0;
    do begin step(); n++; end while (!o_press[2] && n < 40);
    check("press2_lat", 32'(n), 32'(CNT + 2));
    n = 0;
    do begin step(); n++; end while (!o_hold[2] && n < 80);
    check("hold2_lat", 32'(n), 32'(HLD));
    check("hold2_rep0", 32'(o_repeat[2]), 32'd1);
    for (int r = 1; r <= 2; r++) begin
      n = 0;
      do begin step(); n++; end while (!o_repeat[2] && n < 40);
      check("rep2_gap", 32'(n), 32'(REP));
    end
    run(60 - HLD - 2 * REP);
    key_in[2] = 1'b1;
    n = 0;
    do begin step(); n++; end while (!o_release[2] && n < 40);
    check("rel2_lat", 32'(n), 32'(CNT + 2));
    check("rel2_hold_drop", 32'(o_hold[2]), 32'd0);
    run(5);

    // Keys 0 and 3 together; key 0 still held from earlier, release it first
    key_in = '1;
    run(20);
    key_in[0] = 1'b0; key_in[3] = 1'b0;
    n = 0;
    do begin step(); n++; end while (o_press == '0 && n < 40);
    check("press_both", 32'(o_press), 32'b1001);
    run(5);
    key_in[0] = 1'b1; key_in[3] = 1'b1;
    n = 0;
    do begin step(); n++; end while (o_release == '0 && n < 40);
    check("release_both", 32'(o_release), 32'b1001);
    run(5);

    // Reset while key 2 is held, then re-accept after exit
    key_in[2] = 1'b0;
    n = 0;
    do begin step(); n++; end while (!o_hold[2] && n < 100);
    check("hold2_again", 32'(o_hold[2]), 32'd1);
    i_rst_n = 1'b0;
    step();
    check("rst_all0", 32'({o_level, o_press, o_release, o_hold, o_repeat}), 32'd0);
    run(3);
    i_rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (!o_press[2] && n < 40);
    check("press2_after_rst", 32'(n), 32'(CNT + 2));
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
